mmu_access_sequencer: RTL

//  Upstream stage of the mmu: turns valid/ready load/store requests from the core into mmu cycles.

---
 rtl/mmu_access_sequencer_if.sv | 32 +++
 rtl/mmu_access_sequencer.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/mmu_access_sequencer_if.sv
// Bundle of the core-side request/response handshake and the mmu word port.
//   req_*  : core -> sequencer load/store request (valid/ready)
//   rsp_*  : sequencer -> core response (valid/ready)
//   mmu_*  : sequencer <-> mmu (address_in, mode, data_in, data_out)
// slave  : the sequencer's view.
// master : the environment's view (core plus mmu).
interface mmu_access_sequencer_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_write;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_error;
    logic [31:0] mmu_address;
    logic        mmu_mode;
    logic [31:0] mmu_wdata;
    logic [31:0] mmu_rdata;

    modport slave (
        input  req_valid, req_addr, req_write, req_wdata, req_be, rsp_ready, mmu_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_error, mmu_address, mmu_mode, mmu_wdata
    );

    modport master (
        output req_valid, req_addr, req_write, req_wdata, req_be, rsp_ready, mmu_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_error, mmu_address, mmu_mode, mmu_wdata
    );
endinterface

// File: rtl/mmu_access_sequencer.sv
// Upstream stage of the mmu: turns core load/store requests into mmu cycles.
// Loads wait out the mmu's registered read latency; partial-byte stores are done as
// read-modify-write because the mmu is word-only; misaligned or unmapped addresses are
// answered with an error without touching the mmu.
// Ports:
//   clock  : system clock
//   reset  : synchronous, active-high
//   bus    : mmu_access_sequencer_if.slave (req_*, rsp_*, mmu_* signals)
// Parameters:
//   READ_LATENCY : cycles from mmu address stable to mmu data_out valid (1..4)
//   MAPPED_END   : highest mapped byte address (inclusive)
module mmu_access_sequencer #(
    parameter int unsigned READ_LATENCY = 1,
    parameter logic [31:0] MAPPED_END   = 32'h0000_0fff
) (
    input logic                   clock,
    input logic                   reset,
    mmu_access_sequencer_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StRdWait, StWrite, StResp} state_e;

    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        write_q, write_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] mmu_address_q, mmu_address_d;
    logic        mmu_mode_q, mmu_mode_d;
    logic [31:0] mmu_wdata_q, mmu_wdata_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_error_q, rsp_error_d;

    logic        accept;
    logic        bad_addr;
    logic        store_none;
    logic        store_full;
    logic [31:0] merged;

    assign bus.req_ready = (state_q == StIdle) && !reset;
    assign accept        = bus.req_valid && bus.req_ready;
    assign bad_addr      = (bus.req_addr[1:0] != 2'b00) || (bus.req_addr > MAPPED_END);
    assign store_none    = bus.req_write && (bus.req_be == 4'h0);
    assign store_full    = bus.req_write && (bus.req_be == 4'hf);

    // Enabled bytes come from the store data, the rest from the word just read.
    always_comb begin
        merged = '0;
        for (int i = 0; i < 4; i++) begin
            merged[8*i +: 8] = be_q[i] ? wdata_q[8*i +: 8] : bus.mmu_rdata[8*i +: 8];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (bad_addr || store_none) begin
                        state_d = StResp;
                    end else if (store_full) begin
                        state_d = StWrite;
                    end else begin
                        state_d = StRdWait;
                    end
                end
            end
            StRdWait: begin
                if (cnt_q == 3'd0) begin
                    state_d = write_q ? StWrite : StResp;
                end
            end
            StWrite: state_d = StResp;
            StResp: begin
                if (bus.rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Next values of the registered outputs and request latches.
    always_comb begin
        cnt_d         = cnt_q;
        write_d       = write_q;
        be_d          = be_q;
        wdata_d       = wdata_q;
        mmu_address_d = mmu_address_q;
        mmu_mode_d    = mmu_mode_q;
        mmu_wdata_d   = mmu_wdata_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_error_d   = rsp_error_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    write_d     = bus.req_write;
                    be_d        = bus.req_be;
                    wdata_d     = bus.req_wdata;
                    rsp_rdata_d = '0;
                    rsp_error_d = 1'b0;
                    if (bad_addr) begin
                        rsp_valid_d = 1'b1;
                        rsp_error_d = 1'b1;
                    end else if (store_none) begin
                        rsp_valid_d = 1'b1;
                    end else if (store_full) begin
                        mmu_address_d = bus.req_addr;
                        mmu_mode_d    = 1'b1;
                        mmu_wdata_d   = bus.req_wdata;
                    end else begin
                        mmu_address_d = bus.req_addr;
                        mmu_mode_d    = 1'b0;
                        cnt_d         = 3'(READ_LATENCY);
                    end
                end
            end
            StRdWait: begin
                // cnt starts at READ_LATENCY, so this state lasts READ_LATENCY+1 cycles.
                if (cnt_q == 3'd0) begin
                    if (write_q) begin
                        wdata_d     = merged;
                        mmu_wdata_d = merged;
                        mmu_mode_d  = 1'b1;
                    end else begin
                        rsp_valid_d = 1'b1;
                        rsp_rdata_d = bus.mmu_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            StWrite: begin
                mmu_mode_d  = 1'b0;
                rsp_valid_d = 1'b1;
                rsp_rdata_d = '0;
                rsp_error_d = 1'b0;
            end
            StResp: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q         <= '0;
            write_q       <= 1'b0;
            be_q          <= '0;
            wdata_q       <= '0;
            mmu_address_q <= '0;
            mmu_mode_q    <= 1'b0;
            mmu_wdata_q   <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_error_q   <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            write_q       <= write_d;
            be_q          <= be_d;
            wdata_q       <= wdata_d;
            mmu_address_q <= mmu_address_d;
            mmu_mode_q    <= mmu_mode_d;
            mmu_wdata_q   <= mmu_wdata_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_error_q   <= rsp_error_d;
        end
    end

    assign bus.mmu_address = mmu_address_q;
    assign bus.mmu_mode    = mmu_mode_q;
    assign bus.mmu_wdata   = mmu_wdata_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_rdata   = rsp_rdata_q;
    assign bus.rsp_error   = rsp_error_q;

endmodule
